// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB-to-writeback bundle, the decode-stage read ports and
// the debug counters, gathered into one interface.
//   master : pipeline side. Drives the MEM/WB bundle and the read addresses,
//            and receives read data, wb_data/wb_commit and the counters.
//   slave  : the wb_regfile side of the same signals.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic [1:0]        wb_RegSrc;
  logic              wb_RegWrite;
  logic              wb_load_signal;
  logic [DATA_W-1:0] wb_ALUOut;
  logic [DATA_W-1:0] wb_Mem_dataOut;
  logic [15:0]       wb_immediate;
  logic [ADDR_W-1:0] wb_write_reg_dest;
  logic              wb_stall;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic [DATA_W-1:0] wb_data;
  logic              wb_commit;
  logic [CNT_W-1:0]  write_cnt;
  logic [CNT_W-1:0]  load_cnt;

  modport master (
    output wb_RegSrc, wb_RegWrite, wb_load_signal, wb_ALUOut, wb_Mem_dataOut,
           wb_immediate, wb_write_reg_dest, wb_stall, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, wb_data, wb_commit, write_cnt, load_cnt
  );

  modport slave (
    input  wb_RegSrc, wb_RegWrite, wb_load_signal, wb_ALUOut, wb_Mem_dataOut,
           wb_immediate, wb_write_reg_dest, wb_stall, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, wb_data, wb_commit, write_cnt, load_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and architectural register file.
// Selects the writeback value (ALU / load / upper-imm / sign-extended imm),
// commits it to a 2^ADDR_W-entry register file on the rising edge, and serves
// two combinational read ports with same-cycle write-through bypass. It also
// keeps saturating commit counters for total writes and for loads.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wb_regfile_if.slave. Carries the MEM/WB bundle, the read ports,
//           wb_data/wb_commit and the counters.
// The interface instance must be built with the same DATA_W/ADDR_W/CNT_W.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          rst_n,
  wb_regfile_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  write_cnt_q, write_cnt_d;
  logic [CNT_W-1:0]  load_cnt_q,  load_cnt_d;
  logic [DATA_W-1:0] wb_data;
  logic              wb_commit;
  logic              bypass_en;

  always_comb begin
    unique case (bus.wb_RegSrc)
      2'b00:   wb_data = bus.wb_ALUOut;
      2'b01:   wb_data = bus.wb_Mem_dataOut;
      2'b10:   wb_data = {bus.wb_immediate, {(DATA_W-16){1'b0}}};
      default: wb_data = {{(DATA_W-16){bus.wb_immediate[15]}}, bus.wb_immediate};
    endcase
  end

  // Load-sourced data without the load flag is not a valid load, so it never commits.
  assign wb_commit = bus.wb_RegWrite & ~bus.wb_stall
                   & (bus.wb_write_reg_dest != '0)
                   & ~((bus.wb_RegSrc == 2'b01) & ~bus.wb_load_signal);

  // While reset is held the read ports show the cleared file, even if the
  // inputs would otherwise request a bypass.
  assign bypass_en = wb_commit & rst_n;

  always_comb begin
    regs_d = regs_q;
    if (wb_commit) regs_d[bus.wb_write_reg_dest] = wb_data;
    write_cnt_d = write_cnt_q;
    load_cnt_d  = load_cnt_q;
    if (wb_commit && write_cnt_q != '1) write_cnt_d = write_cnt_q + 1'b1;
    if (wb_commit && bus.wb_load_signal && load_cnt_q != '1)
      load_cnt_d = load_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      write_cnt_q <= '0;
      load_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      write_cnt_q <= write_cnt_d;
      load_cnt_q  <= load_cnt_d;
    end
  end

  always_comb begin
    if (bus.rd_addr1 == '0)                                  bus.rd_data1 = '0;
    else if (bypass_en && bus.rd_addr1 == bus.wb_write_reg_dest) bus.rd_data1 = wb_data;
    else                                                     bus.rd_data1 = regs_q[bus.rd_addr1];
    if (bus.rd_addr2 == '0)                                  bus.rd_data2 = '0;
    else if (bypass_en && bus.rd_addr2 == bus.wb_write_reg_dest) bus.rd_data2 = wb_data;
    else                                                     bus.rd_data2 = regs_q[bus.rd_addr2];
  end

  assign bus.wb_data   = wb_data;
  assign bus.wb_commit = wb_commit;
  assign bus.write_cnt = write_cnt_q;
  assign bus.load_cnt  = load_cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile. The main instance m uses the default
// parameters. Instance s uses CNT_W=4 and exercises counter saturation.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bm ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bs ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) m (.clk(clk), .rst_n(rst_n), .bus(bm));
  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  s (.clk(clk), .rst_n(rst_n), .bus(bs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one MEM/WB bundle on instance m at the falling edge.
  task automatic drv(input logic [1:0] src, input logic we, input logic ld,
                     input logic [31:0] alu, input logic [31:0] mem,
                     input logic [15:0] imm, input logic [4:0] dest,
                     input logic stall);
    @(negedge clk);
    bm.wb_RegSrc = src; bm.wb_RegWrite = we; bm.wb_load_signal = ld;
    bm.wb_ALUOut = alu; bm.wb_Mem_dataOut = mem; bm.wb_immediate = imm;
    bm.wb_write_reg_dest = dest; bm.wb_stall = stall;
    #1;
  endtask

  task automatic idle();
    drv(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 5'd0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    bm.rd_addr1 = a1; bm.rd_addr2 = a2; #1;
  endtask

  task automatic edge_wait();
    @(posedge clk); #1;
  endtask

  initial begin
    bm.wb_RegSrc = 0; bm.wb_RegWrite = 0; bm.wb_load_signal = 0; bm.wb_ALUOut = 0;
    bm.wb_Mem_dataOut = 0; bm.wb_immediate = 0; bm.wb_write_reg_dest = 0;
    bm.wb_stall = 0; bm.rd_addr1 = 0; bm.rd_addr2 = 0;
    bs.wb_RegSrc = 0; bs.wb_RegWrite = 0; bs.wb_load_signal = 0; bs.wb_ALUOut = 0;
    bs.wb_Mem_dataOut = 0; bs.wb_immediate = 0; bs.wb_write_reg_dest = 0;
    bs.wb_stall = 0; bs.rd_addr1 = 0; bs.rd_addr2 = 0;

    // Reset state
    #12;
    rd(5'd5, 5'd31);
    chk("rst_rd1", bm.rd_data1, 32'h0);
    chk("rst_rd2", bm.rd_data2, 32'h0);
    chk("rst_wcnt", bm.write_cnt, 32'h0);
    chk("rst_lcnt", bm.load_cnt, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Source select
    drv(2'b00, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 16'h0, 5'd3, 1'b0);
    chk("src00_data", bm.wb_data, 32'hDEADBEEF);
    chk("src00_commit", {31'h0, bm.wb_commit}, 32'h1);
    edge_wait();
    drv(2'b10, 1'b1, 1'b0, 32'h0, 32'h0, 16'hABCD, 5'd4, 1'b0);
    chk("src10_data", bm.wb_data, 32'hABCD0000);
    edge_wait();
    drv(2'b11, 1'b1, 1'b0, 32'h0, 32'h0, 16'h8001, 5'd6, 1'b0);
    chk("src11_data", bm.wb_data, 32'hFFFF8001);
    edge_wait();
    idle();
    rd(5'd3, 5'd4);
    chk("r3", bm.rd_data1, 32'hDEADBEEF);
    chk("r4", bm.rd_data2, 32'hABCD0000);
    rd(5'd6, 5'd0);
    chk("r6", bm.rd_data1, 32'hFFFF8001);
    chk("r0_rd2", bm.rd_data2, 32'h0);
    chk("wcnt3", bm.write_cnt, 32'd3);

    // Load path
    drv(2'b01, 1'b1, 1'b1, 32'h0, 32'h00000077, 16'h0, 5'd7, 1'b0);
    chk("load_commit", {31'h0, bm.wb_commit}, 32'h1);
    edge_wait();
    drv(2'b01, 1'b1, 1'b0, 32'h0, 32'h00000088, 16'h0, 5'd8, 1'b0);
    chk("badload_commit", {31'h0, bm.wb_commit}, 32'h0);
    edge_wait();
    idle();
    rd(5'd7, 5'd8);
    chk("r7", bm.rd_data1, 32'h77);
    chk("r8", bm.rd_data2, 32'h0);
    chk("lcnt1", bm.load_cnt, 32'd1);
    chk("wcnt4", bm.write_cnt, 32'd4);

    // Register 0 never written
    drv(2'b00, 1'b1, 1'b0, 32'h5, 32'h0, 16'h0, 5'd0, 1'b0);
    chk("r0_commit", {31'h0, bm.wb_commit}, 32'h0);
    edge_wait();
    idle();
    rd(5'd0, 5'd0);
    chk("r0_rd", bm.rd_data1, 32'h0);
    chk("r0_wcnt", bm.write_cnt, 32'd4);

    // Stall: no commit, no bypass, counters hold
    drv(2'b00, 1'b1, 1'b0, 32'h99, 32'h0, 16'h0, 5'd9, 1'b1);
    rd(5'd9, 5'd9);
    chk("stall_commit", {31'h0, bm.wb_commit}, 32'h0);
    chk("stall_nobyp", bm.rd_data1, 32'h0);
    edge_wait();
    idle();
    rd(5'd9, 5'd9);
    chk("stall_r9", bm.rd_data1, 32'h0);
    chk("stall_wcnt", bm.write_cnt, 32'd4);

    // Bypass on both ports in the commit cycle, then from regs
    drv(2'b00, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0, 16'h0, 5'd10, 1'b0);
    rd(5'd10, 5'd10);
    chk("byp_rd1", bm.rd_data1, 32'hCAFEF00D);
    chk("byp_rd2", bm.rd_data2, 32'hCAFEF00D);
    edge_wait();
    idle();
    chk("reg_rd1", bm.rd_data1, 32'hCAFEF00D);
    chk("reg_rd2", bm.rd_data2, 32'hCAFEF00D);
    chk("wcnt5", bm.write_cnt, 32'd5);

    // Back-to-back commits to one register: last wins, each counted
    drv(2'b00, 1'b1, 1'b0, 32'h1, 32'h0, 16'h0, 5'd11, 1'b0);
    edge_wait();
    drv(2'b00, 1'b1, 1'b0, 32'h2, 32'h0, 16'h0, 5'd11, 1'b0);
    edge_wait();
    idle();
    rd(5'd11, 5'd0);
    chk("b2b_r11", bm.rd_data1, 32'h2);
    chk("b2b_wcnt", bm.write_cnt, 32'd7);

    // Mid-cycle reset discards the pending commit and clears everything
    drv(2'b00, 1'b1, 1'b0, 32'h1234, 32'h0, 16'h0, 5'd5, 1'b0);
    edge_wait();
    drv(2'b00, 1'b1, 1'b0, 32'h5555, 32'h0, 16'h0, 5'd5, 1'b0);
    rd(5'd5, 5'd7);
    chk("pre_rst_byp", bm.rd_data1, 32'h5555);
    rst_n = 1'b0; #1;
    chk("rst_r5", bm.rd_data1, 32'h0);
    chk("rst_r7", bm.rd_data2, 32'h0);
    chk("rst_wcnt2", bm.write_cnt, 32'h0);
    chk("rst_lcnt2", bm.load_cnt, 32'h0);
    edge_wait();
    chk("rst_hold_r5", bm.rd_data1, 32'h0);
    idle();
    @(negedge clk); rst_n = 1'b1;
    rd(5'd5, 5'd3);
    chk("post_rst_r5", bm.rd_data1, 32'h0);
    chk("post_rst_r3", bm.rd_data2, 32'h0);

    // Saturation on the 4-bit-counter instance
    @(negedge clk);
    bs.wb_RegSrc = 2'b01; bs.wb_RegWrite = 1'b1; bs.wb_load_signal = 1'b1;
    bs.wb_Mem_dataOut = 32'h42; bs.wb_write_reg_dest = 5'd1;
    repeat (15) edge_wait();
    chk("sat15_wcnt", {28'h0, bs.write_cnt}, 32'd15);
    chk("sat15_lcnt", {28'h0, bs.load_cnt}, 32'd15);
    repeat (5) edge_wait();
    chk("sat20_wcnt", {28'h0, bs.write_cnt}, 32'd15);
    chk("sat20_lcnt", {28'h0, bs.load_cnt}, 32'd15);
    bs.rd_addr1 = 5'd1; bs.wb_RegWrite = 1'b0; #1;
    chk("sat_r1", bs.rd_data1, 32'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
